// File: rtl/imm_decode_stage.sv
// Registered RV32I/RV64I immediate-decode stage between fetch and execute.
// Emits the extended immediate, a format code, an illegal flag and a PC-relative target.
module imm_decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32,
  parameter int unsigned SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_tgt,
  output logic            out_tgt_ok,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr
);

  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [2:0] FmtR     = 3'd0;
  localparam logic [2:0] FmtI     = 3'd1;
  localparam logic [2:0] FmtS     = 3'd2;
  localparam logic [2:0] FmtB     = 3'd3;
  localparam logic [2:0] FmtU     = 3'd4;
  localparam logic [2:0] FmtJ     = 3'd5;
  localparam logic [2:0] FmtShift = 3'd6;
  localparam logic [2:0] FmtIll   = 3'd7;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] tgt;
    logic [2:0]      fmt;
    logic            illegal;
    logic            tgt_ok;
  } entry_t;

  // Immediate candidates, each built to exactly XLEN bits.
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic [5:0]      shamt;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  entry_t          dec;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign shamt  = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};

  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
  assign imm_j  = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21],
                   1'b0};
  assign imm_sh = XLEN'(shamt);

  always_comb begin
    dec       = '0;
    dec.instr = in_instr;
    dec.pc    = in_pc;
    case (opcode)
      OpImm: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.imm = imm_sh;
          dec.fmt = FmtShift;
        end else begin
          dec.imm = imm_i;
          dec.fmt = FmtI;
        end
      end
      OpLoad, OpJalr: begin
        // JALR target depends on rs1, which is not available here.
        dec.imm = imm_i;
        dec.fmt = FmtI;
      end
      OpStore: begin
        dec.imm = imm_s;
        dec.fmt = FmtS;
      end
      OpBranch: begin
        dec.imm    = imm_b;
        dec.fmt    = FmtB;
        dec.tgt_ok = 1'b1;
      end
      OpLui: begin
        dec.imm = imm_u;
        dec.fmt = FmtU;
      end
      OpAuipc: begin
        dec.imm    = imm_u;
        dec.fmt    = FmtU;
        dec.tgt_ok = 1'b1;
      end
      OpJal: begin
        dec.imm    = imm_j;
        dec.fmt    = FmtJ;
        dec.tgt_ok = 1'b1;
      end
      OpReg: begin
        dec.fmt = FmtR;
      end
      default: begin
        dec.fmt     = FmtIll;
        dec.illegal = 1'b1;
      end
    endcase
    dec.tgt = dec.tgt_ok ? (XLEN'(in_pc) + dec.imm) : '0;
  end

  // Main register drives the outputs; skid register catches a beat taken during a stall.
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   rdy_q, rdy_d;
  logic   accept, drain;

  assign in_ready = (SKID != 0) ? rdy_q : (rdy_q & (~main_valid_q | out_ready));
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
        if (accept) begin
          skid_d       = dec;
          skid_valid_d = 1'b1;
        end
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Only reachable with the skid buffer enabled: main is stalled and full.
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    rdy_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      rdy_q        <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      rdy_q        <= rdy_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_tgt     = main_q.tgt;
  assign out_tgt_ok  = main_q.tgt_ok;
  assign out_pc      = main_q.pc;
  assign out_instr   = main_q.instr;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed self-checking bench: one SKID=1 and one SKID=0 instance share stimulus;
// sel picks which instance's outputs are observed.
module tb_imm_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready, sel;
  logic [31:0] in_instr, in_pc;

  logic        rdy1, v1, ill1, ok1, rdy0, v0, ill0, ok0;
  logic [31:0] imm1, tgt1, pc1, ins1, imm0, tgt0, pc0, ins0;
  logic [2:0]  fmt1, fmt0;

  logic        o_rdy, o_valid, o_ill, o_ok;
  logic [31:0] o_imm, o_tgt, o_pc, o_instr;
  logic [2:0]  o_fmt;

  int checks = 0;
  int failures = 0;

  imm_decode_stage #(.XLEN(32), .PC_W(32), .SKID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(v1), .out_ready(out_ready),
    .out_imm(imm1), .out_fmt(fmt1), .out_illegal(ill1), .out_tgt(tgt1), .out_tgt_ok(ok1),
    .out_pc(pc1), .out_instr(ins1)
  );

  imm_decode_stage #(.XLEN(32), .PC_W(32), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(v0), .out_ready(out_ready),
    .out_imm(imm0), .out_fmt(fmt0), .out_illegal(ill0), .out_tgt(tgt0), .out_tgt_ok(ok0),
    .out_pc(pc0), .out_instr(ins0)
  );

  assign o_rdy   = sel ? rdy1 : rdy0;
  assign o_valid = sel ? v1 : v0;
  assign o_ill   = sel ? ill1 : ill0;
  assign o_ok    = sel ? ok1 : ok0;
  assign o_imm   = sel ? imm1 : imm0;
  assign o_tgt   = sel ? tgt1 : tgt0;
  assign o_pc    = sel ? pc1 : pc0;
  assign o_instr = sel ? ins1 : ins0;
  assign o_fmt   = sel ? fmt1 : fmt0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] tgt;
    logic [2:0]  fmt;
    logic        ill;
    logic        ok;
  } vec_t;

  vec_t vecs[11];

  task automatic idle();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sel      = 1'b1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00100093;
    in_pc    = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (v1 !== 1'b0 || v0 !== 1'b0) begin
        failures++;
        $display("FAIL reset_valid cyc%0d: got %b/%b want 0/0", i, v1, v0);
      end
      checks++;
      if (rdy1 !== 1'b0 || rdy0 !== 1'b0) begin
        failures++;
        $display("FAIL reset_ready cyc%0d: got %b/%b want 0/0", i, rdy1, rdy0);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rdy1 !== 1'b1 || rdy0 !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b/%b want 1/1", rdy1, rdy0);
    end
    checks++;
    if (v1 !== 1'b0 || imm1 !== 32'h0 || ins1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_release_data: got v=%b imm=%h instr=%h want 0/0/0", v1, imm1, ins1);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_formats(input logic s);
    sel = s;
    idle();
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = vecs[i].pc;
      @(posedge clk);
      #1;
      checks++;
      if (o_valid !== 1'b1 || o_instr !== vecs[i].instr || o_pc !== vecs[i].pc) begin
        failures++;
        $display("FAIL fmt_pass sel%0d v%0d: got v=%b instr=%h pc=%h want 1 %h %h", s, i,
                 o_valid, o_instr, o_pc, vecs[i].instr, vecs[i].pc);
      end
      checks++;
      if (o_imm !== vecs[i].imm) begin
        failures++;
        $display("FAIL fmt_imm sel%0d v%0d: got %h want %h", s, i, o_imm, vecs[i].imm);
      end
      checks++;
      if (o_fmt !== vecs[i].fmt || o_ill !== vecs[i].ill) begin
        failures++;
        $display("FAIL fmt_code sel%0d v%0d: got fmt=%0d ill=%b want %0d %b", s, i, o_fmt,
                 o_ill, vecs[i].fmt, vecs[i].ill);
      end
      checks++;
      if (o_tgt !== vecs[i].tgt || o_ok !== vecs[i].ok) begin
        failures++;
        $display("FAIL fmt_tgt sel%0d v%0d: got tgt=%h ok=%b want %h %b", s, i, o_tgt, o_ok,
                 vecs[i].tgt, vecs[i].ok);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back(input logic s);
    int          tx, rx;
    logic        held;
    logic [31:0] snap_instr, snap_imm;
    logic [31:0] want;
    sel  = s;
    idle();
    tx   = 0;
    rx   = 0;
    held = 1'b0;
    snap_instr = '0;
    snap_imm   = '0;
    for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
      in_valid  = (tx < 6);
      in_instr  = 32'h00000093 + ((tx + 1) << 20);
      in_pc     = 32'h200 + 4 * tx;
      out_ready = !(cyc == 3 || cyc == 4);
      #1;
      if (held) begin
        checks++;
        if (o_instr !== snap_instr || o_imm !== snap_imm || o_valid !== 1'b1) begin
          failures++;
          $display("FAIL stall_stable sel%0d cyc%0d: got %h/%h want %h/%h", s, cyc, o_instr,
                   o_imm, snap_instr, snap_imm);
        end
      end
      if (s && cyc == 3) begin
        checks++;
        if (o_rdy !== 1'b1) begin
          failures++;
          $display("FAIL skid_ready_first_stall: got %b want 1", o_rdy);
        end
      end
      if (s && cyc == 4) begin
        checks++;
        if (o_rdy !== 1'b0) begin
          failures++;
          $display("FAIL skid_ready_fall: got %b want 0", o_rdy);
        end
      end
      if (o_valid && out_ready) begin
        want = 32'h00000093 + ((rx + 1) << 20);
        checks++;
        if (o_instr !== want || o_imm !== 32'(rx + 1)) begin
          failures++;
          $display("FAIL order sel%0d #%0d: got %h imm %h want %h imm %h", s, rx, o_instr,
                   o_imm, want, rx + 1);
        end
        rx++;
      end
      held       = o_valid & ~out_ready;
      snap_instr = o_instr;
      snap_imm   = o_imm;
      if (in_valid && o_rdy) tx++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (rx != 6) begin
      failures++;
      $display("FAIL b2b_count sel%0d: got %0d want 6", s, rx);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_flush();
    sel = 1'b1;
    idle();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00A00093;
    @(posedge clk);
    #1;
    in_instr = 32'h00B00093;
    @(posedge clk);
    #1;
    checks++;
    if (o_rdy !== 1'b0 || o_valid !== 1'b1 || o_instr !== 32'h00A00093) begin
      failures++;
      $display("FAIL flush_setup: got rdy=%b v=%b instr=%h want 0 1 00a00093", o_rdy, o_valid,
               o_instr);
    end
    flush    = 1'b1;
    in_instr = 32'h00C00093;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (o_valid !== 1'b0 || o_rdy !== 1'b1) begin
      failures++;
      $display("FAIL flush_clear: got v=%b rdy=%b want 0 1", o_valid, o_rdy);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (o_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_leak cyc%0d: got v=1 instr=%h want v=0", i, o_instr);
      end
    end
    in_valid = 1'b1;
    in_instr = 32'h00D00093;
    in_pc    = 32'h300;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_instr !== 32'h00D00093 || o_imm !== 32'hD) begin
      failures++;
      $display("FAIL flush_resume: got v=%b instr=%h imm=%h want 1 00d00093 d", o_valid,
               o_instr, o_imm);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_instr  = '0;
    in_pc     = '0;
    sel       = 1'b1;
    vecs[0]  = '{32'hFFF00093, 32'h0,    32'hFFFFFFFF, 32'h0,        3'd1, 1'b0, 1'b0};
    vecs[1]  = '{32'h40315093, 32'h4,    32'h00000003, 32'h0,        3'd6, 1'b0, 1'b0};
    vecs[2]  = '{32'h12345537, 32'h8,    32'h12345000, 32'h0,        3'd4, 1'b0, 1'b0};
    vecs[3]  = '{32'hFE000EE3, 32'h100,  32'hFFFFFFFC, 32'h000000FC, 3'd3, 1'b0, 1'b1};
    vecs[4]  = '{32'h0010006F, 32'h1000, 32'h00000800, 32'h00001800, 3'd5, 1'b0, 1'b1};
    vecs[5]  = '{32'h0000007F, 32'h10,   32'h0,        32'h0,        3'd7, 1'b1, 1'b0};
    vecs[6]  = '{32'h00001517, 32'h2000, 32'h00001000, 32'h00003000, 3'd4, 1'b0, 1'b1};
    vecs[7]  = '{32'hFE112E23, 32'h40,   32'hFFFFFFFC, 32'h0,        3'd2, 1'b0, 1'b0};
    vecs[8]  = '{32'h002081B3, 32'h44,   32'h0,        32'h0,        3'd0, 1'b0, 1'b0};
    vecs[9]  = '{32'h00C08067, 32'h500,  32'h0000000C, 32'h0,        3'd1, 1'b0, 1'b0};
    vecs[10] = '{32'hFE000EE3, 32'h0,    32'hFFFFFFFC, 32'hFFFFFFFC, 3'd3, 1'b0, 1'b1};

    test_reset();
    test_formats(1'b1);
    test_formats(1'b0);
    test_back_to_back(1'b1);
    test_back_to_back(1'b0);
    test_flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, handshaked immediate-decode stage for the RV32I core. It accepts an instruction word and its PC, and emits the sign-extended immediate, a format code, an illegal-opcode flag and a precomputed PC-relative target. All outputs are registered and the stage sits between fetch and execute. It generalises the combinational immediate generator with XLEN-parametrised extension, AUIPC/load/JALR coverage, ready/valid flow control with an optional skid buffer, and flush.

## Interface
- XLEN, 32: immediate/target width; 32 or 64. Shift amount is 5 bits at 32, 6 bits at 64.
- PC_W, 32: PC width; must be ≤ XLEN.
- SKID, 1: 1 = two-entry skid buffer, full throughput under registered in_ready; 0 = single register, in_ready = !out_valid | out_ready.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  drop all held entries
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction address
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_imm  out  XLEN  extended immediate
- out_fmt  out  3  0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 shift-imm, 7 illegal
- out_illegal  out  1  opcode not decoded
- out_tgt  out  XLEN  pc + imm
- out_tgt_ok  out  1  out_tgt meaningful (B, J, AUIPC)
- out_pc  out  PC_W  pass-through PC
- out_instr  out  32  pass-through instruction word

## Operation
- Decode uses opcode = instr[6:0] and funct3 = instr[14:12].
- I (0010011 except shifts, 0000011, 1100111): imm = sext(instr[31:20]).
- Shift (0010011, funct3 001/101): imm = zext(shamt). out_fmt = 6.
- S (0100011): sext({instr[31:25], instr[11:7]}).
- B (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- U (0110111 LUI, 0010111 AUIPC): {instr[31:12], 12'b0}, sign-extended to XLEN.
- J (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- R (0110011): imm = 0, fmt = 0.
- Any other opcode: imm = 0, fmt = 7, out_illegal = 1, out_tgt_ok = 0.
- out_tgt = zext(pc) + imm, modulo 2^XLEN (wraps silently).
- out_tgt_ok = 1 only for B, J and AUIPC. JALR gives 0 because rs1 is not known here. Otherwise out_tgt = 0.
- Entries leave strictly in arrival order. None are lost or duplicated.
- SKID=1: the main register feeds the outputs and the skid register catches the beat accepted while the output stalls.
  - in_ready = !skid_full, registered.
  - A skid entry moves to main on the cycle main drains.

## Timing
- Reset while rst_n = 0 at a clock edge:
  - out_valid = 0, skid empty, in_ready = 0.
  - All data outputs = 0.
  - in_ready = 1 from the first cycle after rst_n is sampled high.
- Reset mid-operation discards all entries.
- Latency: accept at edge N gives out_valid = 1 with data after edge N (visible in cycle N+1).
- Transfer happens when valid & ready at the rising edge.
- While out_valid & !out_ready, every out_* holds stable.
- Throughput is one per cycle with out_ready held high, for both SKID values.
- SKID=1 stall: in_ready stays 1 for the first stalled cycle and drops to 0 the cycle after the skid fills. It returns to 1 the cycle after main drains.
- flush at edge N: out_valid = 0 and skid empty after N. A coincident in_valid beat is dropped, and so is a coincident output transfer's successor.
- flush has priority over accept. rst_n has priority over flush.
- Simultaneous drain and accept with main full and skid empty: the new beat goes to main with no bubble.

## Test plan
- Reset: hold rst_n low 3 cycles with in_valid = 1.
  - out_valid = 0 and in_ready = 0 throughout.
  - in_ready = 1 the cycle after release.
- Immediate formats (XLEN=32, out_ready=1):
  - 0xFFF00093 → imm 0xFFFFFFFF, fmt 1.
  - 0x40315093 → imm 0x3, fmt 6.
  - 0x12345537 → imm 0x12345000, fmt 4, tgt_ok 0.
- Targets:
  - 0xFE000EE3 at pc 0x100 → imm 0xFFFFFFFC, tgt 0xFC, fmt 3, tgt_ok 1.
  - 0x0010006F at pc 0x1000 → imm 0x800, tgt 0x1800, fmt 5.
- Illegal: 0x0000007F → fmt 7, illegal 1, imm 0, tgt_ok 0.
- Backpressure, SKID=1 and SKID=0:
  - Drive 6 back-to-back instructions and drop out_ready for 2 cycles mid-stream.
  - Required: all 6 emerged in order, outputs stable during the stall.
  - SKID=1: in_ready falls exactly one cycle after the stall begins.
- Flush: with main and skid full, assert flush together with in_valid.
  - Next cycle out_valid = 0, and none of the three instructions ever appear.
  - The next accepted instruction appears one cycle after accept.
